rif_timer_regs: RTL and testbench

Register-interface slave that sits directly downstream of the AHB-Lite adapter and consumes its `rif_*` request stream. It provides a small register bank: ID, scratch, control, and a prescaled down-counting timer with a sticky W1C status and interrupt output. It also produces the `rif_addr_valid` decode and `rif_rdata` that the adapter turns into `HRESP` and `HRDATA`.

---
 rtl/rif_timer_regs.sv | 162 ++++++++++++++++
 tb/tb_rif_timer_regs.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rif_timer_regs.sv
// rtl/rif_timer_regs.sv - register-interface slave: ID, scratch, control and prescaled down-counting timer
module rif_timer_regs #(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'h4148_0001
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic [ADDR_WIDTH-1:0]   rif_addr,
   output logic                    rif_addr_valid,
   input  logic                    rif_wr_req,
   input  logic                    rif_rd_req,
   input  logic [DATA_WIDTH/8-1:0] rif_wstrb,
   input  logic [DATA_WIDTH-1:0]   rif_wdata,
   output logic [DATA_WIDTH-1:0]   rif_rdata,
   output logic                    irq,
   output logic                    expire_pulse
);

   localparam int NB = DATA_WIDTH / 8;

   localparam logic [2:0] REG_ID      = 3'd0;
   localparam logic [2:0] REG_SCRATCH = 3'd1;
   localparam logic [2:0] REG_CTRL    = 3'd2;
   localparam logic [2:0] REG_LOAD    = 3'd3;
   localparam logic [2:0] REG_COUNT   = 3'd4;
   localparam logic [2:0] REG_STATUS  = 3'd5;

   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $fatal(1, "rif_timer_regs: only DATA_WIDTH=32 is supported");
   end
   if (ADDR_WIDTH < 6) begin : g_bad_addr_width
      $fatal(1, "rif_timer_regs: ADDR_WIDTH must be at least 6");
   end

   logic [DATA_WIDTH-1:0] scratch_q;
   logic [DATA_WIDTH-1:0] load_q;
   logic [DATA_WIDTH-1:0] count_q;
   logic                  ctrl_en;
   logic                  ctrl_ar;
   logic                  ctrl_ie;
   logic [7:0]            ctrl_pre;
   logic [7:0]            presc_q;
   logic                  st_exp;
   logic                  st_ovr;

   logic [2:0]            reg_idx;
   logic                  wr_hit;
   logic                  wr_scratch;
   logic                  wr_ctrl;
   logic                  wr_load;
   logic                  wr_status;
   logic [DATA_WIDTH-1:0] ctrl_word;
   logic [DATA_WIDTH-1:0] status_word;
   logic [DATA_WIDTH-1:0] ctrl_wr_val;
   logic [DATA_WIDTH-1:0] load_wr_val;
   logic [DATA_WIDTH-1:0] scratch_wr_val;
   logic                  tick;
   logic                  expire;
   logic                  decrement;
   logic                  en_rise;
   logic                  w1c_exp;
   logic                  w1c_ovr;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_v,
      input logic [DATA_WIDTH-1:0] new_v,
      input logic [NB-1:0]         strb
   );
      logic [DATA_WIDTH-1:0] r;
      r = old_v;
      for (int i = 0; i < NB; i++) begin
         if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   assign reg_idx        = rif_addr[4:2];
   assign rif_addr_valid = (rif_addr[1:0] == 2'b00) &&
                           (rif_addr[ADDR_WIDTH-1:5] == '0) &&
                           (reg_idx <= REG_STATUS);

   assign ctrl_word   = {{(DATA_WIDTH-16){1'b0}}, ctrl_pre, 5'b0, ctrl_ie, ctrl_ar, ctrl_en};
   assign status_word = {{(DATA_WIDTH-2){1'b0}}, st_ovr, st_exp};

   always_comb begin
      wr_hit         = rif_wr_req & rif_addr_valid;
      wr_scratch     = wr_hit && (reg_idx == REG_SCRATCH);
      wr_ctrl        = wr_hit && (reg_idx == REG_CTRL);
      wr_load        = wr_hit && (reg_idx == REG_LOAD);
      wr_status      = wr_hit && (reg_idx == REG_STATUS);
      ctrl_wr_val    = merge_lanes(ctrl_word, rif_wdata, rif_wstrb);
      load_wr_val    = merge_lanes(load_q, rif_wdata, rif_wstrb);
      scratch_wr_val = merge_lanes(scratch_q, rif_wdata, rif_wstrb);
      tick           = ctrl_en && (presc_q == ctrl_pre);
      // A LOAD write pre-empts any tick on the same edge
      expire         = tick && (count_q == '0) && !wr_load;
      decrement      = tick && (count_q != '0) && !wr_load;
      en_rise        = wr_ctrl && !ctrl_en && ctrl_wr_val[0];
      w1c_exp        = wr_status && rif_wstrb[0] && rif_wdata[0];
      w1c_ovr        = wr_status && rif_wstrb[0] && rif_wdata[1];
   end

   always_comb begin
      rif_rdata = '0;
      if (rif_rd_req && rif_addr_valid) begin
         case (reg_idx)
            REG_ID:      rif_rdata = ID_VALUE;
            REG_SCRATCH: rif_rdata = scratch_q;
            REG_CTRL:    rif_rdata = ctrl_word;
            REG_LOAD:    rif_rdata = load_q;
            REG_COUNT:   rif_rdata = count_q;
            REG_STATUS:  rif_rdata = status_word;
            default:     rif_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         scratch_q    <= '0;
         load_q       <= '0;
         count_q      <= '0;
         ctrl_en      <= 1'b0;
         ctrl_ar      <= 1'b0;
         ctrl_ie      <= 1'b0;
         ctrl_pre     <= '0;
         presc_q      <= '0;
         st_exp       <= 1'b0;
         st_ovr       <= 1'b0;
         irq          <= 1'b0;
         expire_pulse <= 1'b0;
      end else begin
         expire_pulse <= expire;
         irq          <= ctrl_ie & st_exp;

         if (wr_scratch) scratch_q <= scratch_wr_val;
         if (wr_load)    load_q    <= load_wr_val;

         if (wr_load)                 count_q <= load_wr_val;
         else if (decrement)          count_q <= count_q - 1'b1;
         else if (expire && ctrl_ar)  count_q <= load_q;

         if (wr_load || en_rise)      presc_q <= '0;
         else if (ctrl_en)            presc_q <= tick ? 8'd0 : presc_q + 8'd1;

         // Software write to CTRL beats the one-shot auto-disable
         if (wr_ctrl) begin
            ctrl_en  <= ctrl_wr_val[0];
            ctrl_ar  <= ctrl_wr_val[1];
            ctrl_ie  <= ctrl_wr_val[2];
            ctrl_pre <= ctrl_wr_val[15:8];
         end else if (expire && !ctrl_ar) begin
            ctrl_en  <= 1'b0;
         end

         st_exp <= (st_exp & ~w1c_exp) | expire;
         st_ovr <= (st_ovr & ~w1c_ovr) | (expire & st_exp);
      end
   end

endmodule

// File: tb/tb_rif_timer_regs.sv
// tb/tb_rif_timer_regs.sv - directed self-checking bench for rif_timer_regs
module tb_rif_timer_regs;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic [11:0] rif_addr = '0;
   logic        rif_addr_valid;
   logic        rif_wr_req = 1'b0;
   logic        rif_rd_req = 1'b0;
   logic [3:0]  rif_wstrb = '0;
   logic [31:0] rif_wdata = '0;
   logic [31:0] rif_rdata;
   logic        irq;
   logic        expire_pulse;

   int n_checks = 0;
   int n_pass   = 0;

   rif_timer_regs #(
      .ADDR_WIDTH (12),
      .DATA_WIDTH (32),
      .ID_VALUE   (32'h4148_0001)
   ) dut (
      .HCLK           (HCLK),
      .HRESETn        (HRESETn),
      .rif_addr       (rif_addr),
      .rif_addr_valid (rif_addr_valid),
      .rif_wr_req     (rif_wr_req),
      .rif_rd_req     (rif_rd_req),
      .rif_wstrb      (rif_wstrb),
      .rif_wdata      (rif_wdata),
      .rif_rdata      (rif_rdata),
      .irq            (irq),
      .expire_pulse   (expire_pulse)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
      rif_addr   = addr;
      rif_wdata  = data;
      rif_wstrb  = strb;
      rif_wr_req = 1'b1;
      @(posedge HCLK);
      #1;
      rif_wr_req = 1'b0;
      rif_wstrb  = '0;
   endtask

   task automatic rd(input logic [11:0] addr, output logic [31:0] data);
      rif_addr   = addr;
      rif_rd_req = 1'b1;
      #1;
      data       = rif_rdata;
      rif_rd_req = 1'b0;
   endtask

   logic [31:0] d;
   int          npulse;

   initial begin
      // Reset and read-only registers
      #12;
      HRESETn = 1'b1;
      cyc(1);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_pulse", {31'b0, expire_pulse}, 32'h0);
      rd(12'h000, d); check("rd_id", d, 32'h4148_0001);
      rd(12'h010, d); check("rst_count", d, 32'h0);
      rd(12'h014, d); check("rst_status", d, 32'h0);
      rd(12'h008, d); check("rst_ctrl", d, 32'h0);
      rd(12'h018, d); check("inv18_data", d, 32'h0);
      check("inv18_valid", {31'b0, rif_addr_valid}, 32'h0);
      rd(12'h006, d); check("inv06_data", d, 32'h0);
      check("inv06_valid", {31'b0, rif_addr_valid}, 32'h0);
      rif_addr = 12'h00C; #1;
      check("valid_no_req", {31'b0, rif_addr_valid}, 32'h1);

      // Byte strobes
      wr(12'h004, 32'hDEAD_BEEF, 4'hF);
      wr(12'h004, 32'h1122_3344, 4'b0101);
      rd(12'h004, d); check("scratch_strb", d, 32'hDE22_BE44);

      // One-shot, PRESCALE=0
      wr(12'h00C, 32'd3, 4'hF);
      wr(12'h008, 32'h5, 4'hF);
      rd(12'h010, d); check("os_cnt3", d, 32'd3);
      cyc(1); rd(12'h010, d); check("os_cnt2", d, 32'd2);
      cyc(1); rd(12'h010, d); check("os_cnt1", d, 32'd1);
      cyc(1); rd(12'h010, d); check("os_cnt0", d, 32'd0);
      check("os_no_pulse_yet", {31'b0, expire_pulse}, 32'h0);
      cyc(1);
      check("os_pulse", {31'b0, expire_pulse}, 32'h1);
      rd(12'h014, d); check("os_status", d, 32'h1);
      rd(12'h008, d); check("os_en_clr", d, 32'h4);
      check("os_irq_lag", {31'b0, irq}, 32'h0);
      cyc(1);
      check("os_pulse_1cyc", {31'b0, expire_pulse}, 32'h0);
      check("os_irq", {31'b0, irq}, 32'h1);
      rd(12'h010, d); check("os_cnt_hold", d, 32'd0);
      wr(12'h014, 32'h1, 4'h1);
      rd(12'h014, d); check("os_w1c", d, 32'h0);
      check("os_irq_edge1", {31'b0, irq}, 32'h1);
      cyc(1);
      check("os_irq_edge2", {31'b0, irq}, 32'h0);

      // Auto-reload LOAD=1 PRESCALE=2: expiries every 6 cycles
      wr(12'h00C, 32'd1, 4'hF);
      wr(12'h008, 32'h0203, 4'hF);
      npulse = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc(1);
         if (expire_pulse) npulse++;
         if (c == 6) begin
            check("ar_pulse6", {31'b0, expire_pulse}, 32'h1);
            rd(12'h014, d); check("ar_status1", d, 32'h1);
         end
         if (c == 12) begin
            check("ar_pulse12", {31'b0, expire_pulse}, 32'h1);
            rd(12'h014, d); check("ar_overrun", d, 32'h3);
            check("ar_irq_off", {31'b0, irq}, 32'h0);
         end
      end
      check("ar_npulse", npulse, 32'd2);
      wr(12'h014, 32'h3, 4'hF);
      rd(12'h014, d); check("ar_w1c", d, 32'h0);
      cyc(4);
      wr(12'h014, 32'h1, 4'hF);
      check("ar_coll_pulse", {31'b0, expire_pulse}, 32'h1);
      rd(12'h014, d); check("ar_set_wins", d, 32'h1);

      // LOAD write collides with a COUNT==0 tick
      wr(12'h008, 32'h0, 4'hF);
      wr(12'h014, 32'h3, 4'hF);
      wr(12'h00C, 32'd0, 4'hF);
      wr(12'h008, 32'h3, 4'hF);
      wr(12'h00C, 32'd5, 4'hF);
      rd(12'h010, d); check("col_count", d, 32'd5);
      check("col_no_pulse", {31'b0, expire_pulse}, 32'h0);
      rd(12'h014, d); check("col_status", d, 32'h0);
      cyc(1); rd(12'h010, d); check("col_cnt_dec", d, 32'd4);

      // Asynchronous reset mid-count with irq high
      wr(12'h008, 32'h7, 4'hF);
      cyc(8);
      check("ar_pre_irq", {31'b0, irq}, 32'h1);
      rd(12'h010, d); check("ar_pre_cnt", d, 32'd1);
      HRESETn = 1'b0;
      #1;
      check("arst_irq", {31'b0, irq}, 32'h0);
      check("arst_pulse", {31'b0, expire_pulse}, 32'h0);
      rd(12'h010, d); check("arst_count", d, 32'h0);
      rd(12'h008, d); check("arst_ctrl", d, 32'h0);
      cyc(2);
      HRESETn = 1'b1;
      npulse = 0;
      for (int c = 0; c < 20; c++) begin
         cyc(1);
         if (expire_pulse || irq) npulse++;
      end
      check("arst_quiet", npulse, 32'd0);
      rd(12'h014, d); check("arst_status", d, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
